hyperbus_wb_bridge: RTL

- Wishbone B4 classic 32-bit slave that turns bus cycles into single-word commands on the user side of the Hyperbus dual-port FIFO block.
- Sits directly upstream of that FIFO block, in the user clock domain.
- Only one transaction is outstanding at a time. Writes wait for the TX path to drain. Reads block until the RX word returns.

---
 rtl/hyperbus_wb_bridge.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/hyperbus_wb_bridge.sv
// Purpose: Wishbone B4 classic 32-bit slave that turns each bus cycle into one
//          single-word command on the user side of the Hyperbus dual-port FIFO block.
// Latency: write ack >= 2 cycles after acceptance (1 cycle after fifo_wrq);
//          read ack 1 cycle after fifo_rx_valid.
// Backpressure: one transaction outstanding; writes stall until the TX path is
//          drained and the holdoff has expired, reads stall until fifo_rx_valid.
//
// Ports:
//   clk, rst                      user clock, synchronous active-high reset
//   wb_*                          Wishbone B4 classic slave (byte address in)
//   fifo_rrq / fifo_wrq           one-cycle read / write command pulses
//   fifo_adr_o, fifo_tx_dat_o     command address and write data, held between commands
//   fifo_tx_ready                 TX FIFO empty flag (crosses a CDC, hence the holdoff)
//   fifo_rx_dat_i, fifo_rx_valid  returning read word and its one-cycle strobe
//
// Optional feature: define HYPERBUS_WB_TIMEOUT_EN to give up on a read after
// TIMEOUT_CYCLES cycles in RD_WAIT (wb_err_o pulse, wb_dat_o = 32'hDEAD_BEEF).

module hyperbus_wb_bridge #(
    parameter int WB_ADDR_WIDTH   = 32,
    parameter int FIFO_ADDR_WIDTH = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_SHIFT      = 1,
    parameter int WR_HOLDOFF      = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WB_ADDR_WIDTH-1:0]   wb_adr_i,
    input  logic [DATA_WIDTH-1:0]      wb_dat_i,
    output logic [DATA_WIDTH-1:0]      wb_dat_o,
    input  logic [DATA_WIDTH/8-1:0]    wb_sel_i,
    input  logic                       wb_we_i,
    input  logic                       wb_cyc_i,
    input  logic                       wb_stb_i,
    output logic                       wb_ack_o,
    output logic                       wb_err_o,
    output logic                       fifo_rrq,
    output logic                       fifo_wrq,
    output logic [FIFO_ADDR_WIDTH-1:0] fifo_adr_o,
    output logic [DATA_WIDTH-1:0]      fifo_tx_dat_o,
    input  logic                       fifo_tx_ready,
    input  logic [DATA_WIDTH-1:0]      fifo_rx_dat_i,
    input  logic                       fifo_rx_valid
);

`ifdef HYPERBUS_WB_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam int HO_W = (WR_HOLDOFF < 1) ? 1 : $clog2(WR_HOLDOFF + 1);
    localparam int TO_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_WAIT = 2'd1,
        RD_WAIT = 2'd2,
        ACK     = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [HO_W-1:0]            holdoff_q, holdoff_d;
    logic [TO_W-1:0]            to_cnt_q, to_cnt_d;
    logic                       ack_q, ack_d;
    logic                       err_q, err_d;
    logic                       rrq_q, rrq_d;
    logic [FIFO_ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0]      tx_dat_q, tx_dat_d;
    logic [DATA_WIDTH-1:0]      rd_dat_q, rd_dat_d;

    logic req;
    logic tx_ok;
    logic wrq;

    always_comb begin
        state_d  = state_q;
        to_cnt_d = '0;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        rrq_d    = 1'b0;
        adr_d    = adr_q;
        tx_dat_d = tx_dat_q;
        rd_dat_d = rd_dat_q;
        wrq      = 1'b0;

        req   = wb_cyc_i & wb_stb_i;
        // The TX-empty flag lags a fresh command through the CDC, so it is
        // not trusted until the holdoff has run out.
        tx_ok = fifo_tx_ready & (holdoff_q == '0);

        unique case (state_q)
            IDLE: begin
                // A timeout error is signalled from IDLE; the master still has
                // stb up during that cycle, so do not accept it as a new request.
                if (req && !ack_q && !err_q) begin
                    adr_d = FIFO_ADDR_WIDTH'(wb_adr_i >> ADDR_SHIFT);
                    if (!(&wb_sel_i)) begin
                        err_d   = 1'b1;
                        state_d = ACK;
                    end else if (wb_we_i) begin
                        tx_dat_d = wb_dat_i;
                        state_d  = WR_WAIT;
                    end else begin
                        rrq_d   = 1'b1;
                        state_d = RD_WAIT;
                    end
                end
            end

            WR_WAIT: begin
                // Nothing has been sent yet, so an aborted write is simply dropped.
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else if (tx_ok) begin
                    wrq     = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ACK;
                end
            end

            RD_WAIT: begin
                // The read command is already in flight even if the master
                // aborted, so always wait for (and consume) the returning word.
                if (fifo_rx_valid) begin
                    rd_dat_d = fifo_rx_dat_i;
                    ack_d    = wb_cyc_i;
                    state_d  = ACK;
                end else if (TIMEOUT_EN && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1))) begin
                    err_d    = wb_cyc_i;
                    rd_dat_d = DATA_WIDTH'(32'hDEAD_BEEF);
                    state_d  = IDLE;
                end else if (TIMEOUT_EN) begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end

            ACK: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Every command issue restarts the holdoff; otherwise count down to 0.
        if (wrq || rrq_q) begin
            holdoff_d = HO_W'(WR_HOLDOFF);
        end else if (holdoff_q != '0) begin
            holdoff_d = holdoff_q - HO_W'(1);
        end else begin
            holdoff_d = holdoff_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            holdoff_q <= HO_W'(WR_HOLDOFF);
            to_cnt_q  <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rrq_q     <= 1'b0;
            adr_q     <= '0;
            tx_dat_q  <= '0;
            rd_dat_q  <= '0;
        end else begin
            state_q   <= state_d;
            holdoff_q <= holdoff_d;
            to_cnt_q  <= to_cnt_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rrq_q     <= rrq_d;
            adr_q     <= adr_d;
            tx_dat_q  <= tx_dat_d;
            rd_dat_q  <= rd_dat_d;
        end
    end

    // fifo_wrq is decoded from WR_WAIT so the ack (registered on entry to
    // ACK) lands exactly one cycle after the write command.
    assign fifo_wrq      = wrq;
    assign fifo_rrq      = rrq_q;
    assign fifo_adr_o    = adr_q;
    assign fifo_tx_dat_o = tx_dat_q;
    assign wb_dat_o      = rd_dat_q;
    assign wb_ack_o      = ack_q;
    assign wb_err_o      = err_q;

endmodule
